// File: rtl/branch_request_arbiter.sv
// Branch/exit request arbiter: picks the earliest legal lane request, squashes wrong-path
// requests after a taken branch, and holds halt until resume. Optional stats: BRANCH_ARB_STATS_EN.
module branch_request_arbiter #(
    parameter int LANES         = 4,
    parameter int ADDR_W        = 16,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LANES-1:0]           br_valid,
    input  logic [2*LANES-1:0]         br_kind,
    input  logic [ADDR_W*LANES-1:0]    br_target,
    input  logic                       resume,
    output logic [ADDR_W-1:0]          pc_addr,
    output logic                       pc_add,
    output logic                       pc_load,
    output logic                       pc_stop,
    output logic                       pc_resume,
    output logic [$clog2(LANES)-1:0]   grant_lane,
    output logic                       squashing,
    output logic                       err,
    output logic [15:0]                conflict_cnt
);

    localparam int         LW          = $clog2(LANES);
    localparam logic [1:0] KIND_ADD    = 2'b01;
    localparam logic [1:0] KIND_LOAD   = 2'b10;
    localparam logic [1:0] KIND_STOP   = 2'b11;
    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                add_q, add_d;
    logic                load_q, load_d;
    logic                stop_q, stop_d;
    logic                resume_q, resume_d;
    logic [LW-1:0]       grant_q, grant_d;
    logic                err_q, err_d;

    logic [LANES-1:0]    legal;
    logic                illegal_seen;
    logic                win_found;
    logic [LW-1:0]       win_idx;
    logic [1:0]          win_kind;
    logic [ADDR_W-1:0]   win_target;

    // Lane decode; scanning high-to-low lets the lowest-index legal lane win.
    always_comb begin
        legal        = '0;
        illegal_seen = 1'b0;
        win_found    = 1'b0;
        win_idx      = '0;
        win_kind     = '0;
        win_target   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (br_valid[i]) begin
                if (br_kind[2*i +: 2] == 2'b00) illegal_seen = 1'b1;
                else                            legal[i]     = 1'b1;
            end
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (legal[i]) begin
                win_found  = 1'b1;
                win_idx    = i[LW-1:0];
                win_kind   = br_kind[2*i +: 2];
                win_target = br_target[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        add_d    = 1'b0;
        load_d   = 1'b0;
        stop_d   = stop_q;
        resume_d = 1'b0;
        grant_d  = grant_q;
        err_d    = err_q;
        if (!start) begin
            state_d = RUN;
            cnt_d   = '0;
            stop_d  = 1'b0;
        end else begin
            if (illegal_seen) err_d = 1'b1;
            case (state_q)
                RUN: begin
                    stop_d = 1'b0;
                    if (win_found) begin
                        grant_d = win_idx;
                        case (win_kind)
                            KIND_ADD: begin
                                add_d   = 1'b1;
                                addr_d  = win_target;
                                state_d = SHADOW;
                                cnt_d   = SHADOW_LOAD;
                            end
                            KIND_LOAD: begin
                                load_d  = 1'b1;
                                addr_d  = win_target;
                                state_d = SHADOW;
                                cnt_d   = SHADOW_LOAD;
                            end
                            KIND_STOP: begin
                                stop_d  = 1'b1;
                                state_d = HALTED;
                            end
                            default: ;
                        endcase
                    end
                end
                SHADOW: begin
                    // The command cycle already counts as the first squash cycle.
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        stop_d   = 1'b0;
                        resume_d = 1'b1;
                        state_d  = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            addr_q   <= '0;
            add_q    <= 1'b0;
            load_q   <= 1'b0;
            stop_q   <= 1'b0;
            resume_q <= 1'b0;
            grant_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            add_q    <= add_d;
            load_q   <= load_d;
            stop_q   <= stop_d;
            resume_q <= resume_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
        end
    end

    assign pc_addr    = addr_q;
    assign pc_add     = add_q;
    assign pc_load    = load_q;
    assign pc_stop    = stop_q;
    assign pc_resume  = resume_q;
    assign grant_lane = grant_q;
    assign squashing  = (state_q == SHADOW);
    assign err        = err_q;

`ifdef BRANCH_ARB_STATS_EN
    logic [15:0] conflict_q;
    logic        multi;

    // Two or more legal lanes iff clearing the lowest set bit leaves something.
    assign multi = |(legal & (legal - LANES'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (start && state_q == RUN && win_found && multi && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule
